// File: rtl/jtag_pkg.sv
// JTAG TAP shared definitions.
//   tap_state_e      : 4-bit encoding of the 16 IEEE 1149.1 TAP controller states
//   DEF_*            : default instruction width, opcodes and IDCODE value
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'h0,
    RTI      = 4'h1,
    SEL_DR   = 4'h2,
    CAP_DR   = 4'h3,
    SHIFT_DR = 4'h4,
    EXIT1_DR = 4'h5,
    PAUSE_DR = 4'h6,
    EXIT2_DR = 4'h7,
    UPD_DR   = 4'h8,
    SEL_IR   = 4'h9,
    CAP_IR   = 4'hA,
    SHIFT_IR = 4'hB,
    EXIT1_IR = 4'hC,
    PAUSE_IR = 4'hD,
    EXIT2_IR = 4'hE,
    UPD_IR   = 4'hF
  } tap_state_e;

  localparam int          DEF_IR_WIDTH     = 5;
  localparam logic [31:0] DEF_IDCODE_VALUE = 32'h1000_0DB3;
  localparam logic [4:0]  DEF_IDCODE_INSTR = 5'h01;
  localparam logic [4:0]  DEF_USER_INSTR   = 5'h10;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller next-state logic (purely combinational).
//   state      : current TAP state
//   tms        : test mode select sampled on the next TCK rising edge
//   next_state : state the controller moves to on that edge
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  tap_state_e state,
  input  logic       tms,
  output tap_state_e next_state
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_state = TLR;
    unique case (state)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: state register, instruction register, IDCODE/BYPASS
// data registers and the falling-edge TDO driver.
//   clk_i, trst_ni           : TCK and asynchronous active-low TAP reset
//   tms_i, tdi_i             : mode select and serial data in
//   tdo_o, tdo_oe_o          : serial data out and its drive enable (falling edge)
//   user_sel_o, user_tdo_i   : external user DR select and its serial output
//   capture/shift/update_dr_o: strobes while in Capture-/Shift-/Update-DR
//   tlr_o, ir_o              : Test-Logic-Reset indication and active instruction
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = DEF_IR_WIDTH,
  parameter logic [31:0]         IDCODE_VALUE = DEF_IDCODE_VALUE,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = DEF_IDCODE_INSTR,
  parameter logic [IR_WIDTH-1:0] USER_INSTR   = DEF_USER_INSTR
) (
  input  logic                clk_i,
  input  logic                trst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic                user_sel_o,
  input  logic                user_tdo_i,
  output logic                capture_dr_o,
  output logic                shift_dr_o,
  output logic                update_dr_o,
  output logic                tlr_o,
  output logic [IR_WIDTH-1:0] ir_o
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_q;
  logic [31:0]         idcode_q;
  logic                bypass_q;
  logic                shift_ir, sel_idcode, sel_user;

  jtag_tap_fsm u_fsm (
    .state      (state_q),
    .tms        (tms_i),
    .next_state (state_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TLR;
    else          state_q <= state_d;
  end

  // State-decoded outputs.
  always_comb begin
    tlr_o        = (state_q == TLR);
    capture_dr_o = (state_q == CAP_DR);
    shift_dr_o   = (state_q == SHIFT_DR);
    update_dr_o  = (state_q == UPD_DR);
    shift_ir     = (state_q == SHIFT_IR);
  end

  // The active instruction reads as IDCODE for the whole time the TAP sits in
  // TLR, not just from the clock after entry.
  assign ir_o       = tlr_o ? IDCODE_INSTR : ir_q;
  assign sel_idcode = (ir_o == IDCODE_INSTR);
  assign sel_user   = (ir_o == USER_INSTR) && !sel_idcode;
  assign user_sel_o = sel_user;

  // Instruction register: capture/shift path plus the update (active) copy.
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_shift_q <= '0;
      ir_q       <= IDCODE_INSTR;
    end else begin
      unique case (state_q)
        TLR:      ir_q       <= IDCODE_INSTR;
        CAP_IR:   ir_shift_q <= IR_CAPTURE;
        SHIFT_IR: ir_shift_q <= {tdi_i, ir_shift_q[IR_WIDTH-1:1]};
        UPD_IR:   ir_q       <= ir_shift_q;
        default:  ;
      endcase
    end
  end

  // Internal data registers. The user DR lives outside; when it is selected
  // neither internal register shifts.
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= '0;
      bypass_q <= 1'b0;
    end else if (capture_dr_o) begin
      idcode_q <= IDCODE_VALUE;
      bypass_q <= 1'b0;
    end else if (shift_dr_o) begin
      if (sel_idcode)     idcode_q <= {tdi_i, idcode_q[31:1]};
      else if (!sel_user) bypass_q <= tdi_i;
    end
  end

  // TDO changes on the falling edge so the host samples it on the next rising edge.
  always_ff @(negedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else if (shift_ir) begin
      tdo_o    <= ir_shift_q[0];
      tdo_oe_o <= 1'b1;
    end else if (shift_dr_o) begin
      tdo_o    <= sel_idcode ? idcode_q[0] : (sel_user ? user_tdo_i : bypass_q);
      tdo_oe_o <= 1'b1;
    end else begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end
  end

endmodule
